if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 80 ++++++++
 tb/tb_if_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: word-addressed instruction fetch with IF/ID register, redirect, stall and out-of-range fault
module if_stage #(
  parameter int RESET_PC  = 0,
  parameter int MEM_WORDS = 10240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  input  logic [31:0] ins_in,
  output logic        if_id_valid,
  output logic [31:0] if_id_ins,
  output logic [31:0] if_id_pc_plus1,
  output logic        fault,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, FAULT} state_t;
  localparam logic [31:0] RST_PC = 32'(RESET_PC);
  localparam logic [31:0] LIMIT  = 32'(MEM_WORDS);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ins_q, ins_d, pcp1_q, pcp1_d, cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        in_range;
  assign in_range = pc_q < LIMIT;
  // state register; FAULT is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end
  // a redirect always wins, so only an unredirected out-of-range PC faults
  always_comb state_d = (state_q == RUN && !redirect_valid && !in_range) ? FAULT : state_q;
  // fault flag mirrors the FAULT state
  always_comb fault = (state_q == FAULT);
  // next PC / IF/ID values: redirect beats fault check beats stall beats fetch
  always_comb begin
    pc_d    = pc_q;
    ins_d   = ins_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      if (redirect_valid) begin
        pc_d    = redirect_pc;
        valid_d = 1'b0;
        ins_d   = '0;
      end else if (!in_range) begin
        valid_d = 1'b0;
      end else if (!stall) begin
        ins_d   = ins_in;
        pcp1_d  = pc_q + 32'd1;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd1;
        cnt_d   = cnt_q + 32'd1;
      end
    end
  end
  // PC and IF/ID pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RST_PC;
      ins_q   <= '0;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pc_out         = pc_q;
  assign if_id_ins      = ins_q;
  assign if_id_pc_plus1 = pcp1_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = cnt_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of if_stage fetch, stall, redirect, fault and reset behaviour
module tb_if_stage;
  logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_a, ins_a, iins_a, pcp1_a, cnt_a;
  logic [31:0] pc_b, ins_b, iins_b, pcp1_b, cnt_b;
  logic [31:0] pc_c, ins_c, iins_c, pcp1_c, cnt_c;
  logic        valid_a, fault_a, valid_b, fault_b, valid_c, fault_c;
  int n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] mem(input logic [31:0] p);
    return {16'hC0DE, p[15:0]};
  endfunction

  assign ins_a = mem(pc_a);
  assign ins_b = mem(pc_b);
  assign ins_c = mem(pc_c);

  if_stage dut_a (.clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_out(pc_a), .ins_in(ins_a), .if_id_valid(valid_a),
    .if_id_ins(iins_a), .if_id_pc_plus1(pcp1_a), .fault(fault_a), .fetch_count(cnt_a));
  if_stage #(.MEM_WORDS(16)) dut_b (.clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_out(pc_b), .ins_in(ins_b), .if_id_valid(valid_b),
    .if_id_ins(iins_b), .if_id_pc_plus1(pcp1_b), .fault(fault_b), .fetch_count(cnt_b));
  if_stage #(.RESET_PC(100)) dut_c (.clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_out(pc_c), .ins_in(ins_c), .if_id_valid(valid_c),
    .if_id_ins(iins_c), .if_id_pc_plus1(pcp1_c), .fault(fault_c), .fetch_count(cnt_c));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_assert();
    #2 rst = 1'b1;
    #1;
  endtask

  task automatic rst_release();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_assert();
    n_cmp++;
    if ({pc_a, valid_a, iins_a, pcp1_a, fault_a, cnt_a} !== {32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_a: got pc=%0d v=%b ins=%h p1=%0d f=%b cnt=%0d, want all zero", pc_a, valid_a, iins_a, pcp1_a, fault_a, cnt_a);
    end
    n_cmp++;
    if (pc_c !== 32'd100) begin
      n_bad++;
      $display("FAIL reset_pc_c: got %0d want 100", pc_c);
    end
    rst_release();
  endtask

  task automatic test_seq();
    n_cmp++;
    if (pc_a !== 32'd0) begin
      n_bad++;
      $display("FAIL seq_start_pc: got %0d want 0", pc_a);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if ({pc_a, iins_a, pcp1_a, cnt_a, valid_a} !== {32'(i), mem(32'(i - 1)), 32'(i), 32'(i), 1'b1}) begin
        n_bad++;
        $display("FAIL seq_%0d: got pc=%0d ins=%h p1=%0d cnt=%0d v=%b", i, pc_a, iins_a, pcp1_a, cnt_a, valid_a);
      end
      if (i == 1) begin
        n_cmp++;
        if ({pc_c, pcp1_c, iins_c} !== {32'd101, 32'd101, 32'hC0DE0064}) begin
          n_bad++;
          $display("FAIL seq_c: got pc=%0d p1=%0d ins=%h want 101 101 c0de0064", pc_c, pcp1_c, iins_c);
        end
      end
    end
  endtask

  task automatic test_stall();
    repeat (2) tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({pc_a, iins_a, pcp1_a, cnt_a, valid_a} !== {32'd5, 32'hC0DE0004, 32'd5, 32'd5, 1'b1}) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got pc=%0d ins=%h p1=%0d cnt=%0d v=%b", i, pc_a, iins_a, pcp1_a, cnt_a, valid_a);
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if ({pc_a, iins_a, pcp1_a, cnt_a, valid_a} !== {32'd6, 32'hC0DE0005, 32'd6, 32'd6, 1'b1}) begin
      n_bad++;
      $display("FAIL stall_release: got pc=%0d ins=%h p1=%0d cnt=%0d v=%b", pc_a, iins_a, pcp1_a, cnt_a, valid_a);
    end
  endtask

  task automatic test_redirect();
    repeat (6) tick();
    n_cmp++;
    if ({pc_a, cnt_a} !== {32'd12, 32'd12}) begin
      n_bad++;
      $display("FAIL redir_pre: got pc=%0d cnt=%0d want 12 12", pc_a, cnt_a);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd5;
    stall = 1'b1;
    tick();
    n_cmp++;
    if ({pc_a, valid_a, iins_a, cnt_a} !== {32'd5, 1'b0, 32'd0, 32'd12}) begin
      n_bad++;
      $display("FAIL redir_take: got pc=%0d v=%b ins=%h cnt=%0d want 5 0 0 12", pc_a, valid_a, iins_a, cnt_a);
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    tick();
    n_cmp++;
    if ({pc_a, iins_a, pcp1_a, valid_a, cnt_a} !== {32'd6, 32'hC0DE0005, 32'd6, 1'b1, 32'd13}) begin
      n_bad++;
      $display("FAIL redir_after: got pc=%0d ins=%h p1=%0d v=%b cnt=%0d", pc_a, iins_a, pcp1_a, valid_a, cnt_a);
    end
  endtask

  task automatic test_fault();
    rst_assert();
    rst_release();
    repeat (16) tick();
    n_cmp++;
    if ({pc_b, iins_b, pcp1_b, cnt_b, valid_b, fault_b} !== {32'd16, 32'hC0DE000F, 32'd16, 32'd16, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL fault_last_word: got pc=%0d ins=%h p1=%0d cnt=%0d v=%b f=%b", pc_b, iins_b, pcp1_b, cnt_b, valid_b, fault_b);
    end
    tick();
    n_cmp++;
    if ({pc_b, fault_b, valid_b, cnt_b} !== {32'd16, 1'b1, 1'b0, 32'd16}) begin
      n_bad++;
      $display("FAIL fault_enter: got pc=%0d f=%b v=%b cnt=%0d want 16 1 0 16", pc_b, fault_b, valid_b, cnt_b);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    repeat (2) tick();
    n_cmp++;
    if ({pc_b, fault_b, valid_b, cnt_b, iins_b} !== {32'd16, 1'b1, 1'b0, 32'd16, 32'hC0DE000F}) begin
      n_bad++;
      $display("FAIL fault_ignore_redir: got pc=%0d f=%b v=%b cnt=%0d ins=%h", pc_b, fault_b, valid_b, cnt_b, iins_b);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_far_redirect();
    rst_assert();
    rst_release();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'd20000;
    stall = 1'b1;
    tick();
    n_cmp++;
    if ({pc_a, valid_a, fault_a, cnt_a} !== {32'd20000, 1'b0, 1'b0, 32'd1}) begin
      n_bad++;
      $display("FAIL far_take: got pc=%0d v=%b f=%b cnt=%0d want 20000 0 0 1", pc_a, valid_a, fault_a, cnt_a);
    end
    redirect_valid = 1'b0;
    tick();
    n_cmp++;
    if ({pc_a, valid_a, fault_a, cnt_a} !== {32'd20000, 1'b0, 1'b1, 32'd1}) begin
      n_bad++;
      $display("FAIL far_fault: got pc=%0d v=%b f=%b cnt=%0d want 20000 0 1 1", pc_a, valid_a, fault_a, cnt_a);
    end
    stall = 1'b0;
  endtask

  task automatic test_fault_reset();
    rst_assert();
    rst_release();
    repeat (7) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'd100;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_cmp++;
    if ({fault_b, cnt_b, pc_b} !== {1'b1, 32'd7, 32'd100}) begin
      n_bad++;
      $display("FAIL frst_pre: got f=%b cnt=%0d pc=%0d want 1 7 100", fault_b, cnt_b, pc_b);
    end
    rst_assert();
    n_cmp++;
    if ({pc_b, valid_b, iins_b, pcp1_b, fault_b, cnt_b} !== {32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL frst_async: got pc=%0d v=%b ins=%h p1=%0d f=%b cnt=%0d want all zero", pc_b, valid_b, iins_b, pcp1_b, fault_b, cnt_b);
    end
    rst_release();
    tick();
    n_cmp++;
    if ({pc_b, iins_b, pcp1_b, valid_b, cnt_b, fault_b} !== {32'd1, 32'hC0DE0000, 32'd1, 1'b1, 32'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL frst_resume: got pc=%0d ins=%h p1=%0d v=%b cnt=%0d f=%b", pc_b, iins_b, pcp1_b, valid_b, cnt_b, fault_b);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_redirect();
    test_fault();
    test_far_redirect();
    test_fault_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
